// File: rtl/gshare_predictor.sv
// gshare_predictor: fetch-stage gshare direction predictor.
// Predicts up to FETCH_WIDTH slots per fetch window from a table of 2-bit
// saturating counters indexed by slot PC XOR global history. The GHR is
// updated speculatively, repaired from the EX-carried snapshot on a
// mispredict, and counters are trained on every EX resolution.
// Optional feature: define GSHARE_PRED_BTFN_EN to add a per-entry trained bit.
// Untrained entries then predict backward-taken / forward-not-taken.
module gshare_predictor #(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int PHT_DEPTH   = 10,
    parameter int GHR_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [ADDR_WIDTH-1:0]             pc_now,
    input  logic [FETCH_WIDTH-1:0]            exist,
    input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] target,
    input  logic                              ex_vld,
    input  logic [ADDR_WIDTH-1:0]             ex_pc,
    input  logic [GHR_WIDTH-1:0]              ex_ghr,
    input  logic                              ex_taken,
    input  logic                              ex_wrong,
    output logic [ADDR_WIDTH-1:0]             pc_new,
    output logic                              branch,
    output logic [$clog2(FETCH_WIDTH)-1:0]    slot,
    output logic                              known,
    output logic [GHR_WIDTH-1:0]              ghr_snap
);

    localparam int FW_BITS     = $clog2(FETCH_WIDTH);
    localparam int WIN_W       = ADDR_WIDTH - FW_BITS - 2;
    localparam int PHT_ENTRIES = 1 << PHT_DEPTH;

    logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
    logic [1:0]             pht_q [PHT_ENTRIES];
`ifdef GSHARE_PRED_BTFN_EN
    logic [PHT_ENTRIES-1:0] trained_q;
`endif

    logic [FW_BITS-1:0]     start_slot;
    logic [FETCH_WIDTH-1:0] valid_mask;
    logic [FETCH_WIDTH-1:0] taken_vec;
    logic [PHT_DEPTH-1:0]   idx_v;
    logic                   ctr_taken;
    logic [FW_BITS-1:0]     sel_slot;
    logic [ADDR_WIDTH-1:0]  sel_target;
    logic [WIN_W-1:0]       next_win;
    logic [PHT_DEPTH-1:0]   ex_idx;
    logic                   unused_bits;

    // Two-bit counter saturating at 2'b11.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    // Two-bit counter saturating at 2'b00.
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // gshare hash: PC word bits XOR history zero-extended to the index width.
    function automatic logic [PHT_DEPTH-1:0] hash(input logic [PHT_DEPTH-1:0] pc_bits,
                                                  input logic [GHR_WIDTH-1:0] h);
        logic [PHT_DEPTH-1:0] ext;
        ext = '0;
        ext[GHR_WIDTH-1:0] = h;
        return pc_bits ^ ext;
    endfunction

    // Slots below the window entry point were skipped by the fetch PC.
    assign start_slot = pc_now[FW_BITS+1:2];

    // Per-slot lookup: mask, index and direction for each slot of the window.
    always_comb begin
        valid_mask = '0;
        taken_vec  = '0;
        idx_v      = '0;
        ctr_taken  = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            valid_mask[i] = (FW_BITS'(i) >= start_slot);
            idx_v = hash({pc_now[PHT_DEPTH+1:FW_BITS+2], FW_BITS'(i)}, ghr_q);
            ctr_taken = pht_q[idx_v][1];
`ifdef GSHARE_PRED_BTFN_EN
            if (!trained_q[idx_v])
                ctr_taken = (target[i*ADDR_WIDTH+2 +: ADDR_WIDTH-2] < pc_now[ADDR_WIDTH-1:2]);
`endif
            taken_vec[i] = exist[i] & valid_mask[i] & ctr_taken;
        end
    end

    // Lowest taken slot wins, matching program order within the window.
    always_comb begin
        sel_slot = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (taken_vec[i])
                sel_slot = FW_BITS'(i);
        end
    end

    assign sel_target = target[sel_slot*ADDR_WIDTH +: ADDR_WIDTH];
    assign next_win   = pc_now[ADDR_WIDTH-1:FW_BITS+2] + WIN_W'(1);

    assign branch   = |taken_vec;
    assign known    = |(exist & valid_mask);
    assign slot     = sel_slot;
    assign ghr_snap = ghr_q;
    assign pc_new   = branch ? {sel_target[ADDR_WIDTH-1:2], 2'b00}
                             : {next_win, {(FW_BITS+2){1'b0}}};

    // History next state: mispredict repair outranks the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (ex_vld && ex_wrong)
            ghr_d = {ex_ghr[GHR_WIDTH-2:0], ex_taken};
        else if (en && known)
            ghr_d = {ghr_q[GHR_WIDTH-2:0], branch};
    end

    // Global history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    // Training uses the history the branch was predicted with, not the live GHR.
    assign ex_idx = hash(ex_pc[PHT_DEPTH+1:2], ex_ghr);

    // Counter training on every resolved branch; reset to weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < PHT_ENTRIES; e++)
                pht_q[e] <= 2'b01;
        end else if (ex_vld) begin
            pht_q[ex_idx] <= ex_taken ? sat_inc(pht_q[ex_idx]) : sat_dec(pht_q[ex_idx]);
        end
    end

`ifdef GSHARE_PRED_BTFN_EN
    // Marks an entry as trained on its first resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trained_q <= '0;
        else if (ex_vld)
            trained_q[ex_idx] <= 1'b1;
    end
`endif

    // Byte-offset and high PC bits take no part in indexing.
    assign unused_bits = ^{pc_now[1:0], ex_pc[1:0], ex_pc[ADDR_WIDTH-1:PHT_DEPTH+2],
                           sel_target[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor (default parameters). Each step drives a
// window plus optional EX resolution, pushes the expected prediction to a
// scoreboard queue and compares it mid-cycle against the DUT outputs.
module tb_gshare_predictor;

    localparam logic [31:0] F0 = 32'h0000_3000;
    localparam logic [31:0] F1 = 32'h0000_3004;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] pc_now;
    logic [1:0]  exist;
    logic [63:0] target;
    logic        ex_vld;
    logic [31:0] ex_pc;
    logic [7:0]  ex_ghr;
    logic        ex_taken;
    logic        ex_wrong;
    logic [31:0] pc_new;
    logic        branch;
    logic [0:0]  slot;
    logic        known;
    logic [7:0]  ghr_snap;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic        r, e;
        logic [31:0] pc;
        logic [1:0]  ex;
        logic [31:0] t0, t1;
        logic        xv;
        logic [31:0] xpc;
        logic [7:0]  xg;
        logic        xt, xw;
        logic        br, sl, kn;
        logic [31:0] pcn;
        logic [7:0]  gs;
    } step_t;

    typedef struct {
        string       nm;
        logic        br, sl, kn;
        logic [31:0] pcn;
        logic [7:0]  gs;
    } exp_t;

    step_t stim[$];
    exp_t  sb[$];
    exp_t  ex_e;

    gshare_predictor dut (
        .clk(clk), .rst(rst), .en(en), .pc_now(pc_now), .exist(exist),
        .target(target), .ex_vld(ex_vld), .ex_pc(ex_pc), .ex_ghr(ex_ghr),
        .ex_taken(ex_taken), .ex_wrong(ex_wrong), .pc_new(pc_new),
        .branch(branch), .slot(slot), .known(known), .ghr_snap(ghr_snap)
    );

    always #5 clk = ~clk;

    task automatic st(input string nm, input logic r, input logic e, input logic [31:0] pc,
                      input logic [1:0] ex, input logic [31:0] t0, input logic [31:0] t1,
                      input logic xv, input logic [31:0] xpc, input logic [7:0] xg,
                      input logic xt, input logic xw, input logic br, input logic sl,
                      input logic kn, input logic [31:0] pcn, input logic [7:0] gs);
        step_t s;
        s.nm = nm; s.r = r; s.e = e; s.pc = pc; s.ex = ex; s.t0 = t0; s.t1 = t1;
        s.xv = xv; s.xpc = xpc; s.xg = xg; s.xt = xt; s.xw = xw;
        s.br = br; s.sl = sl; s.kn = kn; s.pcn = pcn; s.gs = gs;
        stim.push_back(s);
    endtask

    // Drive one step's inputs and record its expected outputs.
    task automatic apply();
        step_t s;
        exp_t  x;
        s = stim.pop_front();
        rst = s.r; en = s.e; pc_now = s.pc; exist = s.ex; target = {s.t1, s.t0};
        ex_vld = s.xv; ex_pc = s.xpc; ex_ghr = s.xg; ex_taken = s.xt; ex_wrong = s.xw;
        x.nm = s.nm; x.br = s.br; x.sl = s.sl; x.kn = s.kn; x.pcn = s.pcn; x.gs = s.gs;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        st("rst_idle",   1, 0, 32'h0,    2'b00, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 32'h8,    8'h00);
        st("rst_window", 1, 0, 32'h1000, 2'b11, F0, F1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1008, 8'h00);
        while (stim.size() > 0) begin
            apply();
            #3;
            ex_e = sb.pop_front();
            n_cmp++;
            if ({branch, slot, known, pc_new, ghr_snap} !== {ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs}) begin
                n_bad++;
                $display("FAIL %s: got br=%b slot=%0d known=%b pc_new=%h ghr=%h, want br=%b slot=%0d known=%b pc_new=%h ghr=%h",
                         ex_e.nm, branch, slot, known, pc_new, ghr_snap, ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic();
        st("first_window", 0, 1, 32'h1000,      2'b11, F0, F1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1008, 8'h00);
        st("ghr_after_nt", 0, 1, 32'h1000,      2'b11, F0, F1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1008, 8'h00);
        st("pc_wrap",      0, 0, 32'hFFFF_FFF8, 2'b00, F0, F1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    8'h00);
        st("mask_slot0",   0, 0, 32'h1004,      2'b11, F0, F1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1008, 8'h00);
        while (stim.size() > 0) begin
            apply();
            #3;
            ex_e = sb.pop_front();
            n_cmp++;
            if ({branch, slot, known, pc_new, ghr_snap} !== {ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs}) begin
                n_bad++;
                $display("FAIL %s: got br=%b slot=%0d known=%b pc_new=%h ghr=%h, want br=%b slot=%0d known=%b pc_new=%h ghr=%h",
                         ex_e.nm, branch, slot, known, pc_new, ghr_snap, ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_train_predict();
        st("train1_old",   0, 0, 32'h1000, 2'b10, F0, 32'h2000, 1, 32'h1004, 8'h00, 1, 0, 0, 0, 1, 32'h1008, 8'h00);
        st("train2_old",   0, 0, 32'h1000, 2'b10, F0, 32'h2000, 1, 32'h1004, 8'h00, 1, 0, 1, 1, 1, 32'h2000, 8'h00);
        st("slot1_taken",  0, 0, 32'h1000, 2'b10, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 1, 1, 1, 32'h2000, 8'h00);
        st("train_s0_a",   0, 0, 32'h1004, 2'b01, F0, 32'h2000, 1, 32'h1000, 8'h00, 1, 0, 0, 0, 0, 32'h1008, 8'h00);
        st("train_s0_b",   0, 0, 32'h1004, 2'b01, F0, 32'h2000, 1, 32'h1000, 8'h00, 1, 0, 0, 0, 0, 32'h1008, 8'h00);
        st("slot0_masked", 0, 0, 32'h1004, 2'b01, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 0, 0, 0, 32'h1008, 8'h00);
        st("slot0_taken",  0, 0, 32'h1000, 2'b01, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 1, 0, 1, 32'h3000, 8'h00);
        st("priority_low", 0, 0, 32'h1000, 2'b11, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 1, 0, 1, 32'h3000, 8'h00);
        while (stim.size() > 0) begin
            apply();
            #3;
            ex_e = sb.pop_front();
            n_cmp++;
            if ({branch, slot, known, pc_new, ghr_snap} !== {ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs}) begin
                n_bad++;
                $display("FAIL %s: got br=%b slot=%0d known=%b pc_new=%h ghr=%h, want br=%b slot=%0d known=%b pc_new=%h ghr=%h",
                         ex_e.nm, branch, slot, known, pc_new, ghr_snap, ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_repair();
        st("spec_t_a",     0, 1, 32'h1000, 2'b01, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 1, 0, 1, 32'h3000, 8'h00);
        st("spec_t_b",     0, 1, 32'h1000, 2'b01, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 1, 0, 1, 32'h3000, 8'h01);
        st("repair_wins",  0, 1, 32'h1000, 2'b01, F0, 32'h2000, 1, 32'h1000, 8'h5A, 1, 1, 0, 0, 1, 32'h1008, 8'h03);
        st("ghr_repaired", 0, 0, 32'h1000, 2'b01, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 0, 0, 1, 32'h1008, 8'hB5);
        st("en_unknown",   0, 1, 32'h1000, 2'b00, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 0, 0, 0, 32'h1008, 8'hB5);
        st("ghr_held",     0, 0, 32'h1000, 2'b00, F0, 32'h2000, 0, 0,        8'h00, 0, 0, 0, 0, 0, 32'h1008, 8'hB5);
        while (stim.size() > 0) begin
            apply();
            #3;
            ex_e = sb.pop_front();
            n_cmp++;
            if ({branch, slot, known, pc_new, ghr_snap} !== {ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs}) begin
                n_bad++;
                $display("FAIL %s: got br=%b slot=%0d known=%b pc_new=%h ghr=%h, want br=%b slot=%0d known=%b pc_new=%h ghr=%h",
                         ex_e.nm, branch, slot, known, pc_new, ghr_snap, ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs);
            end
            @(posedge clk); #1;
        end
    endtask

    // Entry 0xB5 starts at 01; each step shows the value before that step's training.
    task automatic test_saturation();
        int xv[17] = '{1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0};
        int xt[17] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
        int br[17] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 17; k++) begin
            st($sformatf("sat_step%0d", k), 0, 0, 32'h1000, 2'b01, F0, 32'h2000,
               1'(xv[k]), 32'h1000, 8'hB5, 1'(xt[k]), 0,
               1'(br[k]), 0, 1, (br[k] != 0) ? 32'h3000 : 32'h1008, 8'hB5);
        end
        while (stim.size() > 0) begin
            apply();
            #3;
            ex_e = sb.pop_front();
            n_cmp++;
            if ({branch, slot, known, pc_new, ghr_snap} !== {ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs}) begin
                n_bad++;
                $display("FAIL %s: got br=%b slot=%0d known=%b pc_new=%h ghr=%h, want br=%b slot=%0d known=%b pc_new=%h ghr=%h",
                         ex_e.nm, branch, slot, known, pc_new, ghr_snap, ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        st("pre_rst_taken", 0, 0, 32'h2000, 2'b11, F0, F1,       0, 0, 0, 0, 0, 1, 0, 1, 32'h3000, 8'hB5);
        st("rst_async",     1, 0, 32'h2000, 2'b11, F0, F1,       0, 0, 0, 0, 0, 0, 0, 1, 32'h2008, 8'h00);
`ifdef GSHARE_PRED_BTFN_EN
        st("rst_backward",  1, 0, 32'h2000, 2'b11, F0, 32'h1000, 0, 0, 0, 0, 0, 1, 1, 1, 32'h1000, 8'h00);
`else
        st("rst_backward",  1, 0, 32'h2000, 2'b11, F0, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2008, 8'h00);
`endif
        st("post_rst",      0, 0, 32'h2000, 2'b11, F0, F1,       0, 0, 0, 0, 0, 0, 0, 1, 32'h2008, 8'h00);
        st("ctr0_cleared",  0, 0, 32'h1000, 2'b01, F0, F1,       0, 0, 0, 0, 0, 0, 0, 1, 32'h1008, 8'h00);
        while (stim.size() > 0) begin
            apply();
            #3;
            ex_e = sb.pop_front();
            n_cmp++;
            if ({branch, slot, known, pc_new, ghr_snap} !== {ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs}) begin
                n_bad++;
                $display("FAIL %s: got br=%b slot=%0d known=%b pc_new=%h ghr=%h, want br=%b slot=%0d known=%b pc_new=%h ghr=%h",
                         ex_e.nm, branch, slot, known, pc_new, ghr_snap, ex_e.br, ex_e.sl, ex_e.kn, ex_e.pcn, ex_e.gs);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pc_now = '0; exist = '0; target = '0;
        ex_vld = 1'b0; ex_pc = '0; ex_ghr = '0; ex_taken = 1'b0; ex_wrong = 1'b0;
        test_reset();
        test_basic();
        test_train_predict();
        test_repair();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the fetch-stage direction predictor.
- Predicts up to FETCH_WIDTH instruction slots per fetch window.
- Uses a gshare pattern history table (PHT) of 2-bit saturating counters, indexed by the slot PC XOR a global history register (GHR).
- Speculatively updates the GHR on each prediction, repairs it from a pipeline-carried snapshot on mispredict, and trains counters on resolution from EX.

Parameters:
- ADDR_WIDTH, 32: PC/target width.
- FETCH_WIDTH, 2: slots per window; power of 2, at least 2. FW_BITS = log2(FETCH_WIDTH).
- PHT_DEPTH, 10: PHT has 2^PHT_DEPTH entries.
- GHR_WIDTH, 8: history length; must be at most PHT_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  fetch window accepted this cycle; advances GHR
- pc_now  in  ADDR_WIDTH  fetch window PC
- exist  in  FETCH_WIDTH  bit i set: slot i holds a conditional branch
- target  in  FETCH_WIDTH*ADDR_WIDTH  slot i target at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- ex_vld  in  1  branch resolved in EX
- ex_pc  in  ADDR_WIDTH  resolved branch PC
- ex_ghr  in  GHR_WIDTH  ghr_snap carried with that branch
- ex_taken  in  1  actual direction
- ex_wrong  in  1  direction mispredicted
- pc_new  out  ADDR_WIDTH  next fetch PC
- branch  out  1  predicted taken
- slot  out  FW_BITS  index of the taken slot
- known  out  1  some valid slot holds a branch
- ghr_snap  out  GHR_WIDTH  GHR used for this prediction

Behaviour:
- Reset (async, rst=1):
  - GHR = 0.
  - All counters = 2'b01.
  - Outputs are combinational from state, so with pc_now/exist at 0: branch=0, slot=0, known=0, ghr_snap=0.
- Slot i PC = {pc_now[A-1:FW_BITS+2], i[FW_BITS-1:0], 2'b00}.
  - Valid slots: i >= pc_now[FW_BITS+1:2]; lower slots are masked.
- idx_i = slotpc_i[PHT_DEPTH+1:2] XOR zero-extended GHR.
  - Slot i predicts taken when exist[i], slot valid, and pht[idx_i][1].
- branch = OR of per-slot taken.
- slot = lowest taken index (priority to program order).
- known = OR of (exist AND valid mask).
- pc_new:
  - branch: {target_slot[A-1:2], 2'b00}.
  - else: {pc_now[A-1:FW_BITS+2]+1, zeros}; wraps modulo 2^ADDR_WIDTH.
- ghr_snap = current GHR (pre-update).
- Prediction is combinational, zero latency. All state updates take effect at the next posedge.
- GHR next-state priority:
  - ex_vld & ex_wrong: {ex_ghr[GHR_WIDTH-2:0], ex_taken}.
  - else en & known: {GHR[GHR_WIDTH-2:0], branch}.
  - else hold.
  - Repair wins over a same-cycle speculative update.
- Training on ex_vld: entry ex_pc[PHT_DEPTH+1:2] XOR ex_ghr.
  - Increment if ex_taken, saturating at 11.
  - Decrement otherwise, saturating at 00.
  - Trains regardless of ex_wrong and en.
- Same-cycle train and read of one entry: prediction sees the old value.
- en=0 does not block training or repair.
- Reset mid-operation: all state is cleared immediately; in-flight ex_ghr values are not special-cased.

Optional Feature:
- Macro GSHARE_PRED_BTFN_EN.
- Defined:
  - Adds a per-entry trained bit, reset to 0, set on any training write.
  - For an untrained entry, the slot predicts taken iff target_i[A-1:2] < pc_now[A-1:2] (backward taken).
- Undefined: counters alone decide; no trained array.

Test Plan:
- Reset, then pc_now=0x1000, exist=2'b11, en=1 -> branch=0, known=1, pc_new=0x1008, ghr_snap=0x00; next cycle GHR=0x00.
- With en=0, two trainings ex_pc=0x1004, ex_ghr=0, ex_taken=1; then pc_now=0x1000, exist=2'b10, target1=0x2000 -> branch=1, slot=1, pc_new=0x2000.
- Train slot0 taken (ex_pc=0x1000, twice); pc_now=0x1004, exist=2'b01 -> slot masked: known=0, branch=0, pc_new=0x1008.
- GHR=0x03, ex_vld=1, ex_wrong=1, ex_ghr=0x5A, ex_taken=1, with en=1 and known=1 in the same cycle -> next GHR=0xB5, speculative update dropped.
- Saturation on one entry:
  - Three taken trainings -> counter 11.
  - One not-taken -> 10, still predicts taken.
  - Second not-taken -> 01, predicts not-taken.
  - Four more not-taken -> stays 00.
- Assert rst mid-run with a trained counter and GHR=0xB5 -> GHR=0x00 and counter=01 immediately; prediction from 0x2000 window not taken. With BTFN_EN, untrained backward target predicts taken.
